// File: rtl/ntt_host_sequencer.sv
// Host-side sequencer for the NTT core: streams twiddles/params and coefficients from a
// 1-cycle-latency source RAM, pulses start, waits for done and unloads RING_SIZE results.
module ntt_host_sequencer #(
  parameter int DATA_SIZE_ARB = 16,
  parameter int RING_SIZE     = 1024,
  parameter int PE_NUMBER     = 8,
  parameter int GAP_CYC       = 5,
  parameter int TIMEOUT       = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_start,
  input  logic                         cmd_skip_w,
  input  logic                         cmd_abort,
  output logic                         src_rd,
  output logic [11:0]                  src_addr,
  input  logic [DATA_SIZE_ARB-1:0]     src_data,
  output logic                         ntt_load_w,
  output logic                         ntt_load_data,
  output logic                         ntt_start,
  output logic [DATA_SIZE_ARB-1:0]     ntt_din,
  input  logic                         ntt_done,
  input  logic [DATA_SIZE_ARB-1:0]     ntt_dout,
  output logic                         out_valid,
  output logic [DATA_SIZE_ARB-1:0]     out_data,
  output logic [$clog2(RING_SIZE)-1:0] out_idx,
  output logic                         busy,
  output logic                         seq_done,
  output logic                         tw_loaded,
  output logic                         err_timeout
);
  localparam int LOGR     = $clog2(RING_SIZE);
  localparam int LOGP     = $clog2(PE_NUMBER);
  localparam int W_WORDS  = ((1 << (LOGR - LOGP)) - 1 + LOGP) * PE_NUMBER;
  localparam int TW_WORDS = 2 * W_WORDS + 2;
  localparam int M1       = (TW_WORDS > RING_SIZE) ? TW_WORDS : RING_SIZE;
  localparam int CMAX     = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int CW       = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TW_LAST   = CW'(TW_WORDS - 1);
  localparam logic [CW-1:0] D_LAST    = CW'(RING_SIZE - 1);
  localparam logic [CW-1:0] GAP1_LAST = CW'(GAP_CYC);
  localparam logic [CW-1:0] GAP2_LAST = CW'(GAP_CYC + 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [11:0]   D_BASE    = 12'(TW_WORDS);

  typedef enum logic [3:0] {
    IDLE, W_PULSE, W_STREAM, GAP1, D_PULSE, D_STREAM, GAP2, S_PULSE, S_GAP, WAIT_DONE, UNLOAD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd_d;

  assign busy = (state != IDLE);

  // Reads lead ntt_din by two cycles (RAM latency + din register). The *_PULSE states
  // issue the first read; the load pulse shows up one cycle later, right before word 0.
  // GAP1 lasts GAP_CYC+1 read-free cycles and GAP2 GAP_CYC+2 so that ntt_din sees
  // exactly GAP_CYC zero cycles between the last word and the next pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_d          <= 1'b0;
      src_rd        <= 1'b0;
      src_addr      <= '0;
      ntt_load_w    <= 1'b0;
      ntt_load_data <= 1'b0;
      ntt_start     <= 1'b0;
      ntt_din       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_idx       <= '0;
      seq_done      <= 1'b0;
      tw_loaded     <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      ntt_load_w    <= 1'b0;
      ntt_load_data <= 1'b0;
      ntt_start     <= 1'b0;
      out_valid     <= 1'b0;
      seq_done      <= 1'b0;
      rd_d          <= src_rd;
      ntt_din       <= rd_d ? src_data : '0;
      if (cmd_abort) begin
        state    <= IDLE;
        cnt      <= '0;
        rd_d     <= 1'b0;
        src_rd   <= 1'b0;
        src_addr <= '0;
        ntt_din  <= '0;
        out_data <= '0;
        out_idx  <= '0;
        // A partial twiddle load leaves the core's twiddle memory inconsistent.
        if (state == W_STREAM) tw_loaded <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              err_timeout <= 1'b0;
              src_rd      <= 1'b1;
              cnt         <= '0;
              if (cmd_skip_w && tw_loaded) begin
                state    <= D_PULSE;
                src_addr <= D_BASE;
              end else begin
                state    <= W_PULSE;
                src_addr <= '0;
              end
            end
          end
          W_PULSE: begin
            ntt_load_w <= 1'b1;
            src_addr   <= src_addr + 12'd1;
            cnt        <= cnt + CW'(1);
            state      <= W_STREAM;
          end
          W_STREAM: begin
            if (cnt == TW_LAST) begin
              src_rd    <= 1'b0;
              src_addr  <= '0;
              cnt       <= '0;
              tw_loaded <= 1'b1;
              state     <= GAP1;
            end else begin
              src_addr <= src_addr + 12'd1;
              cnt      <= cnt + CW'(1);
            end
          end
          GAP1: begin
            if (cnt == GAP1_LAST) begin
              cnt      <= '0;
              src_rd   <= 1'b1;
              src_addr <= D_BASE;
              state    <= D_PULSE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          D_PULSE: begin
            ntt_load_data <= 1'b1;
            src_addr      <= src_addr + 12'd1;
            cnt           <= cnt + CW'(1);
            state         <= D_STREAM;
          end
          D_STREAM: begin
            if (cnt == D_LAST) begin
              src_rd   <= 1'b0;
              src_addr <= '0;
              cnt      <= '0;
              state    <= GAP2;
            end else begin
              src_addr <= src_addr + 12'd1;
              cnt      <= cnt + CW'(1);
            end
          end
          GAP2: begin
            if (cnt == GAP2_LAST) begin
              cnt       <= '0;
              ntt_start <= 1'b1;
              state     <= S_PULSE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_PULSE: state <= S_GAP;
          S_GAP: begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (ntt_done) begin
              cnt   <= '0;
              state <= UNLOAD;
            end else if (cnt == TO_LAST) begin
              err_timeout <= 1'b1;
              cnt         <= '0;
              state       <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          UNLOAD: begin
            out_valid <= 1'b1;
            out_data  <= ntt_dout;
            out_idx   <= cnt[LOGR-1:0];
            if (cnt == D_LAST) begin
              seq_done <= 1'b1;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ntt_host_sequencer.sv
// Bench for ntt_host_sequencer: RAM and core models, per-cycle logs compared against
// a timeline computed from the sequencing rules.
module tb_ntt_host_sequencer;
  localparam int DW      = 16;
  localparam int RING    = 1024;
  localparam int PEN     = 8;
  localparam int GAP     = 5;
  localparam int TMO     = 200;
  localparam int W_WORDS = ((1 << ($clog2(RING) - $clog2(PEN))) - 1 + $clog2(PEN)) * PEN;
  localparam int NW      = 2 * W_WORDS + 2;
  localparam int LOGN    = 4400;

  logic clk, reset, cmd_start, cmd_skip_w, cmd_abort;
  logic src_rd;
  logic [11:0] src_addr;
  logic [DW-1:0] src_data, ntt_din, ntt_dout, out_data;
  logic ntt_load_w, ntt_load_data, ntt_start, ntt_done, out_valid;
  logic [9:0] out_idx;
  logic busy, seq_done, tw_loaded, err_timeout;

  int checks, failures, dly, exp_last;
  bit core_en;
  logic [15:0] mem [4096];
  logic [15:0] res [RING];
  logic [15:0] l_din [LOGN];
  logic [4:0]  l_ctl [LOGN];
  logic [15:0] l_od  [LOGN];
  logic [9:0]  l_oi  [LOGN];
  logic        l_busy[LOGN];
  logic        l_err [LOGN];
  logic [15:0] e_din [LOGN];
  logic [4:0]  e_ctl [LOGN];
  logic [15:0] e_od  [LOGN];
  logic [9:0]  e_oi  [LOGN];

  ntt_host_sequencer #(.DATA_SIZE_ARB(DW), .RING_SIZE(RING), .PE_NUMBER(PEN),
                       .GAP_CYC(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_skip_w(cmd_skip_w),
    .cmd_abort(cmd_abort), .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .ntt_load_w(ntt_load_w), .ntt_load_data(ntt_load_data), .ntt_start(ntt_start),
    .ntt_din(ntt_din), .ntt_done(ntt_done), .ntt_dout(ntt_dout), .out_valid(out_valid),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .seq_done(seq_done),
    .tw_loaded(tw_loaded), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial src_data = '0;
  always @(posedge clk) if (src_rd) src_data <= mem[src_addr];

  // Core model: done 'dly' cycles after the start pulse, then one result per cycle.
  initial begin
    ntt_done = 1'b0;
    ntt_dout = '0;
    forever begin
      @(negedge clk);
      if (ntt_start === 1'b1 && core_en) begin
        repeat (dly) @(negedge clk);
        ntt_done = 1'b1;
        @(negedge clk);
        ntt_done = 1'b0;
        for (int k = 0; k < RING; k++) begin
          ntt_dout = res[k];
          @(negedge clk);
        end
        ntt_dout = '0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench time limit");
  end

  task issue_start(input bit skip);
    cmd_start = 1'b1;
    cmd_skip_w = skip;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_skip_w = 1'b0;
  endtask

  task capture(input int n);
    for (int i = 0; i < n; i++) begin
      l_din[i]  = ntt_din;
      l_ctl[i]  = {ntt_load_w, ntt_load_data, ntt_start, out_valid, seq_done};
      l_od[i]   = out_data;
      l_oi[i]   = out_idx;
      l_busy[i] = busy;
      l_err[i]  = err_timeout;
      @(negedge clk);
    end
  endtask

  // Expected timeline. ctl bits: {load_w, load_data, start, out_valid, seq_done}.
  task build_expect(input int t, input bit skip);
    int t2, s, d;
    for (int i = 0; i < LOGN; i++) begin
      e_din[i] = '0; e_ctl[i] = '0; e_od[i] = '0; e_oi[i] = '0;
    end
    t2 = t;
    if (!skip) begin
      e_ctl[t][4] = 1'b1;
      for (int k = 0; k < NW; k++) e_din[t + 1 + k] = mem[k];
      t2 = t + NW + GAP + 1;
    end
    e_ctl[t2][3] = 1'b1;
    for (int j = 0; j < RING; j++) e_din[t2 + 1 + j] = mem[NW + j];
    s = t2 + RING + GAP + 1;
    e_ctl[s][2] = 1'b1;
    d = s + dly;
    for (int k = 0; k < RING; k++) begin
      e_ctl[d + 2 + k][1] = 1'b1;
      e_od[d + 2 + k] = res[k];
      e_oi[d + 2 + k] = 10'(k);
    end
    exp_last = d + 1 + RING;
    e_ctl[exp_last][0] = 1'b1;
  endtask

  task test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({src_rd, src_addr, ntt_load_w, ntt_load_data, ntt_start, ntt_din, out_valid, out_data,
         out_idx, busy, seq_done, tw_loaded, err_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b src_rd=%b din=%h tw=%b want all zero", busy, src_rd, ntt_din, tw_loaded);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({src_rd, ntt_load_w, ntt_load_data, ntt_start, out_valid, busy, seq_done, tw_loaded} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b src_rd=%b tw=%b want 0", busy, src_rd, tw_loaded);
    end
  endtask

  task test_full_run(input string name);
    int t;
    for (int k = 0; k < 4096; k++) mem[k] = 16'(k);
    for (int k = 0; k < RING; k++) res[k] = 16'(k) ^ 16'hA5A5;
    dly = 100;
    core_en = 1'b1;
    issue_start(1'b0);
    capture(LOGN);
    t = -1;
    for (int i = 0; i < 8; i++) if (t < 0 && l_ctl[i][4]) t = i;
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL %s load_w_pulse: not observed within 8 cycles of cmd_start, want one", name);
      t = 1;
    end
    build_expect(t, 1'b0);
    for (int i = 0; i < LOGN; i++) begin
      checks++;
      if (l_din[i] !== e_din[i] || l_ctl[i] !== e_ctl[i]) begin
        failures++;
        $display("FAIL %s cyc=%0d din/ctl: got %h/%b want %h/%b", name, i, l_din[i], l_ctl[i], e_din[i], e_ctl[i]);
      end
      if (e_ctl[i][1]) begin
        checks++;
        if (l_od[i] !== e_od[i] || l_oi[i] !== e_oi[i]) begin
          failures++;
          $display("FAIL %s cyc=%0d out_data/idx: got %h/%0d want %h/%0d", name, i, l_od[i], l_oi[i], e_od[i], e_oi[i]);
        end
      end
      if (i != exp_last) begin
        checks++;
        if (l_busy[i] !== (i < exp_last)) begin
          failures++;
          $display("FAIL %s cyc=%0d busy: got %b want %b", name, i, l_busy[i], (i < exp_last));
        end
      end
    end
    checks++;
    if (tw_loaded !== 1'b1) begin
      failures++;
      $display("FAIL %s tw_loaded: got %b want 1", name, tw_loaded);
    end
  endtask

  task test_skip_w;
    int t;
    for (int j = 0; j < RING; j++) mem[NW + j] = 16'($urandom);
    for (int k = 0; k < RING; k++) res[k] = 16'($urandom);
    dly = $urandom_range(2, 150);
    issue_start(1'b1);
    capture(LOGN);
    t = -1;
    for (int i = 0; i < 8; i++) if (t < 0 && l_ctl[i][3]) t = i;
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL skip load_data_pulse: not observed within 8 cycles, want one");
      t = 1;
    end
    build_expect(t, 1'b1);
    for (int i = 0; i < LOGN; i++) begin
      checks++;
      if (l_din[i] !== e_din[i] || l_ctl[i] !== e_ctl[i]) begin
        failures++;
        $display("FAIL skip cyc=%0d din/ctl: got %h/%b want %h/%b", i, l_din[i], l_ctl[i], e_din[i], e_ctl[i]);
      end
      if (e_ctl[i][1]) begin
        checks++;
        if (l_od[i] !== e_od[i] || l_oi[i] !== e_oi[i]) begin
          failures++;
          $display("FAIL skip cyc=%0d out_data/idx: got %h/%0d want %h/%0d", i, l_od[i], l_oi[i], e_od[i], e_oi[i]);
        end
      end
    end
  endtask

  task test_timeout;
    int t, s, nov;
    core_en = 1'b0;
    issue_start(1'b1);
    capture(1400);
    t = -1;
    for (int i = 0; i < 8; i++) if (t < 0 && l_ctl[i][3]) t = i;
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL timeout load_data_pulse: not observed within 8 cycles");
      t = 1;
    end
    s = t + RING + GAP + 1;
    checks++;
    if (l_ctl[s][2] !== 1'b1) begin
      failures++;
      $display("FAIL timeout start_pulse: got %b want 1 at cyc %0d", l_ctl[s][2], s);
    end
    checks++;
    if ({l_busy[s + 201], l_err[s + 201]} !== 2'b10) begin
      failures++;
      $display("FAIL timeout last_wait_cycle busy/err: got %b%b want 10", l_busy[s + 201], l_err[s + 201]);
    end
    checks++;
    if ({l_busy[s + 202], l_err[s + 202]} !== 2'b01) begin
      failures++;
      $display("FAIL timeout expiry busy/err: got %b%b want 01", l_busy[s + 202], l_err[s + 202]);
    end
    nov = 0;
    for (int i = 0; i < 1400; i++) if (l_ctl[i][1] || l_ctl[i][0]) nov++;
    checks++;
    if (nov != 0) begin
      failures++;
      $display("FAIL timeout no_output: got %0d valid/seq_done cycles want 0", nov);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout sticky: got %b want 1", err_timeout);
    end
    issue_start(1'b1);
    checks++;
    if ({err_timeout, busy} !== 2'b01) begin
      failures++;
      $display("FAIL timeout clear_on_start err/busy: got %b%b want 01", err_timeout, busy);
    end
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    checks++;
    if ({busy, tw_loaded} !== 2'b01) begin
      failures++;
      $display("FAIL abort_in_data busy/tw_loaded: got %b%b want 01", busy, tw_loaded);
    end
    core_en = 1'b1;
  endtask

  task test_abort;
    int t, lw_n, bad;
    issue_start(1'b0);
    t = -1;
    for (int i = 0; i < 8 && t < 0; i++) begin
      if (ntt_load_w === 1'b1) t = i;
      else @(negedge clk);
    end
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL abort load_w_pulse: not observed within 8 cycles");
    end
    repeat (101) @(negedge clk);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    lw_n = 0;
    repeat (399) begin
      if (ntt_load_w === 1'b1) lw_n++;
      @(negedge clk);
    end
    checks++;
    if (lw_n != 0 || ntt_din !== mem[500]) begin
      failures++;
      $display("FAIL start_ignored_busy: load_w=%0d din=%h want 0 and %h", lw_n, ntt_din, mem[500]);
    end
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    checks++;
    if ({busy, src_rd, ntt_load_w, ntt_load_data, ntt_start, out_valid, tw_loaded, ntt_din} !== '0) begin
      failures++;
      $display("FAIL abort_w_stream: busy=%b src_rd=%b tw=%b din=%h want all 0", busy, src_rd, tw_loaded, ntt_din);
    end
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    bad = 0;
    repeat (4) begin
      if (busy !== 1'b0 || src_rd !== 1'b0 || ntt_load_w !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_with_start: got %0d active cycles want 0", bad);
    end
  endtask

  task test_async_reset;
    int t;
    issue_start(1'b0);
    t = -1;
    for (int i = 0; i < 8 && t < 0; i++) begin
      if (ntt_load_w === 1'b1) t = i;
      else @(negedge clk);
    end
    repeat (NW + GAP + 1 + 300) @(negedge clk);
    checks++;
    if (t < 0 || ntt_din !== mem[NW + 299]) begin
      failures++;
      $display("FAIL mid_d_stream din: got %h want %h", ntt_din, mem[NW + 299]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({src_rd, src_addr, ntt_load_w, ntt_load_data, ntt_start, ntt_din, out_valid, out_data,
         out_idx, busy, seq_done, tw_loaded, err_timeout} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs: busy=%b src_rd=%b din=%h tw=%b want all zero", busy, src_rd, ntt_din, tw_loaded);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_full_run("rerun");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cmd_start = 1'b0;
    cmd_skip_w = 1'b0;
    cmd_abort = 1'b0;
    core_en = 1'b1;
    dly = 100;
    reset = 1'b0;
    for (int k = 0; k < 4096; k++) mem[k] = 16'(k);
    test_reset();
    test_full_run("full");
    test_skip_w();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
